// File: rtl/sobel_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sobel_ctrl_pkg
// Shared definitions for the Sobel frame controller slice: default field
// widths, the controller state encoding and the skid buffer depth.
// ---------------------------------------------------------------------------
package sobel_ctrl_pkg;

    // Default widths: frame dimension fields, memory address, RGB/result data.
    localparam int DIM_W_DEF  = 10;
    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 24;

    // The skid buffer absorbs one read return plus one stalled pixel.
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : sobel_ctrl_pkg

// File: rtl/sobel_skid_fifo.sv
// ---------------------------------------------------------------------------
// sobel_skid_fifo
// Two-entry FIFO that catches pixel-memory read returns so the filter can
// stall (i_rgb_busy) without losing data already requested from memory.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data this cycle (ignored when full and not popping)
//   push_data   entry to write
//   pop         remove the head entry this cycle (ignored when empty)
//   head        current head entry, 0 when empty
//   empty       no entries held
//   count       number of entries held (0..2)
// ---------------------------------------------------------------------------
module sobel_skid_fifo
    import sobel_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [SKID_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic              push_ok;
    logic              pop_ok;

    assign pop_ok  = pop && (cnt != 2'd0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign push_ok = push && ((cnt != 2'd2) || pop_ok);

    // NOTE: the storage is reset along with the pointers so head never shows
    // stale data from an aborted frame; at two entries the cost is negligible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + 2'(push_ok) - 2'(pop_ok);
        end
    end

    assign empty = (cnt == 2'd0);
    assign count = cnt;
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule : sobel_skid_fifo

// File: rtl/sobel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sobel_frame_ctrl
// Frame sequencer around a streaming Sobel filter. On start it reads
// width*height pixels from pixel memory (addresses 0..N-1), streams them to
// the filter through a 2-entry skid buffer, and writes each filter result to
// result memory (addresses 0..N-1). o_done pulses once the N-th result is
// written.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_start                   frame request, sampled in IDLE only
//   i_width, i_height         frame size, captured on the accepted start
//   o_busy / o_done           frame in progress / one-cycle completion pulse
//   o_rd_en, o_rd_addr        pixel memory read request
//   i_rd_data                 pixel memory data, one cycle after o_rd_en
//   o_pix_vld, o_pix_data     pixel stream to the filter
//   i_pix_busy                filter back-pressure on the pixel stream
//   i_res_vld, i_res_data     result stream from the filter
//   o_res_busy                back-pressure on the result stream
//   o_wr_en, o_wr_addr,
//   o_wr_data                 result memory write (never stalls)
// ---------------------------------------------------------------------------
module sobel_frame_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter int DIM_W  = DIM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DIM_W-1:0]  i_width,
    input  logic [DIM_W-1:0]  i_height,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_pix_vld,
    output logic [DATA_W-1:0] o_pix_data,
    input  logic              i_pix_busy,
    input  logic              i_res_vld,
    input  logic [DATA_W-1:0] i_res_data,
    output logic              o_res_busy,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data
);

    localparam int CNT_W = 2 * DIM_W;

    state_t            state;
    logic [CNT_W-1:0]  frame_n;      // size presented on the inputs this cycle
    logic [CNT_W-1:0]  n_total;      // size captured for the running frame
    logic [CNT_W-1:0]  n_last;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  snd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic              rd_inflight;  // a read issued last cycle returns now
    logic              rd_en;
    logic              pix_xfer;
    logic              res_xfer;
    logic [2:0]        occ_next;

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;
    logic [1:0]        fifo_count;

    assign frame_n  = CNT_W'(i_width) * CNT_W'(i_height);
    assign n_last   = n_total - CNT_W'(1);
    assign pix_xfer = o_pix_vld && !i_pix_busy;
    assign res_xfer = i_res_vld && !o_res_busy;

    // Read issue. The occupancy used is what the buffer will hold after this
    // cycle's pop; counting the departing head as still present would halve
    // the streaming rate, while this form still bounds the buffer at two.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        occ_next = 3'd0;
        rd_en    = 1'b0;
        occ_next = {1'b0, fifo_count} - {2'b00, pix_xfer} + {2'b00, rd_inflight};
        if ((state == ST_RUN) && (rd_cnt < n_total) && (occ_next < 3'd2)) begin
            rd_en = 1'b1;
        end
    end

    sobel_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (rd_inflight),
        .push_data (i_rd_data),
        .pop       (pix_xfer),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Frame sequencer. o_busy, o_done and o_res_busy are registered alongside
    // the state so they change exactly on state transitions.
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            n_total     <= '0;
            rd_cnt      <= '0;
            snd_cnt     <= '0;
            wr_cnt      <= '0;
            rd_inflight <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_res_busy  <= 1'b1;
        end else begin
            rd_inflight <= rd_en;
            if (rd_en) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if (pix_xfer) begin
                snd_cnt <= snd_cnt + CNT_W'(1);
            end
            if (res_xfer) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        n_total <= frame_n;
                        rd_cnt  <= '0;
                        snd_cnt <= '0;
                        wr_cnt  <= '0;
                        o_busy  <= 1'b1;
                        if (frame_n == '0) begin
                            // Empty frame: complete without touching memory.
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state      <= ST_RUN;
                            o_res_busy <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    if (pix_xfer && (snd_cnt == n_last)) begin
                        // The last result cannot normally coincide with the
                        // last pixel, but finishing directly keeps it safe.
                        if (res_xfer && (wr_cnt == n_last)) begin
                            state      <= ST_DONE;
                            o_done     <= 1'b1;
                            o_res_busy <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (res_xfer && (wr_cnt == n_last)) begin
                        state      <= ST_DONE;
                        o_done     <= 1'b1;
                        o_res_busy <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end

                default: begin
                    state      <= ST_IDLE;
                    o_done     <= 1'b0;
                    o_busy     <= 1'b0;
                    o_res_busy <= 1'b1;
                end
            endcase
        end
    end

    assign o_rd_en    = rd_en;
    assign o_rd_addr  = ADDR_W'(rd_cnt);
    assign o_pix_vld  = !fifo_empty;
    assign o_pix_data = fifo_head;
    assign o_wr_en    = res_xfer;
    assign o_wr_addr  = ADDR_W'(wr_cnt);
    // Result data passes straight through; forced to zero outside a write.
    assign o_wr_data  = res_xfer ? i_res_data : '0;

endmodule : sobel_frame_ctrl

// File: tb/tb_sobel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sobel_frame_ctrl
// Directed bench for sobel_frame_ctrl. A negedge environment process models
// the pixel memory (1-cycle read latency), the filter (echoes each pixel,
// inverted, after a delay) and logs every read, pixel and write.
// ---------------------------------------------------------------------------
module tb_sobel_frame_ctrl;

    localparam int DIM_W  = 10;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 24;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic [DIM_W-1:0]  i_width = '0;
    logic [DIM_W-1:0]  i_height = '0;
    logic              o_busy;
    logic              o_done;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [DATA_W-1:0] i_rd_data = '0;
    logic              o_pix_vld;
    logic [DATA_W-1:0] o_pix_data;
    logic              i_pix_busy = 1'b0;
    logic              i_res_vld = 1'b0;
    logic [DATA_W-1:0] i_res_data = '0;
    logic              o_res_busy;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;

    always #5 i_clk = ~i_clk;

    sobel_frame_ctrl #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_width    (i_width),
        .i_height   (i_height),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_rd_en    (o_rd_en),
        .o_rd_addr  (o_rd_addr),
        .i_rd_data  (i_rd_data),
        .o_pix_vld  (o_pix_vld),
        .o_pix_data (o_pix_data),
        .i_pix_busy (i_pix_busy),
        .i_res_vld  (i_res_vld),
        .i_res_data (i_res_data),
        .o_res_busy (o_res_busy),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pixel memory contents: a recognisable pattern per address.
    function automatic logic [DATA_W-1:0] pix_val(input int a);
        logic [7:0] lo;
        lo = a[7:0];
        return {8'h5A, lo, ~lo};
    endfunction

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } res_t;

    // Environment state
    int                cyc = 0;
    int                busy_mode = 0;   // 0: never busy, 1: toggle every cycle
    bit                gap_mode = 0;    // hold results until all pixels sent
    int                frame_n = 0;
    logic              rd_pend = 1'b0;
    logic [ADDR_W-1:0] rd_pend_addr = '0;
    res_t              res_q[$];
    logic [ADDR_W-1:0] rd_log[$];
    logic [DATA_W-1:0] pix_log[$];
    logic [ADDR_W-1:0] wr_addr_log[$];
    logic [DATA_W-1:0] wr_data_log[$];
    int                first_vld_cyc = -1;
    int                pix_cyc_first = 0;
    int                pix_cyc_last = 0;
    int                wr_cyc_first = 0;
    int                wr_cyc_last = 0;
    int                done_cyc = 0;
    int                done_cnt = 0;
    int                stab_err = 0;
    int                max_out = 0;
    int                busy_gap = 0;
    int                drain_err = 0;
    bit                in_frame = 0;
    bit                prev_hold = 0;
    logic [DATA_W-1:0] prev_data = '0;

    always @(negedge i_clk) begin
        res_t r;
        cyc++;
        // Drive this cycle's inputs.
        i_rd_data  = rd_pend ? pix_val(int'(rd_pend_addr)) : '0;
        i_pix_busy = (busy_mode == 1) ? ~i_pix_busy : 1'b0;
        if (res_q.size() > 0 && res_q[0].due >= 0 && res_q[0].due <= cyc) begin
            i_res_vld  = 1'b1;
            i_res_data = res_q[0].data;
        end else begin
            i_res_vld  = 1'b0;
            i_res_data = '0;
        end
        #1;
        // Observe this cycle's outputs.
        rd_pend      = o_rd_en;
        rd_pend_addr = o_rd_addr;
        if (o_rd_en) rd_log.push_back(o_rd_addr);
        if (prev_hold && (o_pix_vld !== 1'b1 || o_pix_data !== prev_data)) stab_err++;
        prev_hold = o_pix_vld && i_pix_busy;
        prev_data = o_pix_data;
        if (o_pix_vld === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (o_pix_vld === 1'b1 && !i_pix_busy) begin
            if (pix_log.size() == 0) pix_cyc_first = cyc;
            pix_cyc_last = cyc;
            pix_log.push_back(o_pix_data);
            r.due  = gap_mode ? -1 : cyc + 3;
            r.data = o_pix_data ^ 24'hFFFFFF;
            res_q.push_back(r);
            if (gap_mode && pix_log.size() == frame_n) begin
                foreach (res_q[k]) res_q[k].due = cyc + 10 * (k + 1);
            end
        end
        if (rd_log.size() - pix_log.size() > max_out) max_out = rd_log.size() - pix_log.size();
        if (o_wr_en === 1'b1) begin
            if (wr_addr_log.size() == 0) wr_cyc_first = cyc;
            wr_addr_log.push_back(o_wr_addr);
            wr_data_log.push_back(o_wr_data);
            wr_cyc_last = cyc;
            if (res_q.size() > 0) void'(res_q.pop_front());
        end
        if (in_frame && o_busy !== 1'b1) busy_gap++;
        if (gap_mode && pix_log.size() == frame_n && wr_addr_log.size() < frame_n &&
            (o_busy !== 1'b1 || o_done !== 1'b0)) drain_err++;
        if (o_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            in_frame = 0;
        end
    end

    task automatic clear_logs();
        rd_log.delete();
        pix_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        res_q.delete();
        first_vld_cyc = -1;
        done_cnt  = 0;
        stab_err  = 0;
        max_out   = 0;
        busy_gap  = 0;
        drain_err = 0;
        prev_hold = 0;
    endtask

    task automatic step();
        @(negedge i_clk);
        #2;
    endtask

    task automatic start_frame(input int w, input int h, output int c);
        step();
        i_width  = DIM_W'(w);
        i_height = DIM_W'(h);
        i_start  = 1'b1;
        in_frame = 1;
        c        = cyc;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            step();
            k++;
        end
        repeat (4) step();
    endtask

    task automatic wait_pix(input int n, input int budget);
        int k = 0;
        while (pix_log.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    function automatic int rd_seq_err();
        int e = 0;
        foreach (rd_log[k]) if (rd_log[k] !== ADDR_W'(k)) e++;
        return e;
    endfunction

    function automatic int pix_seq_err();
        int e = 0;
        foreach (pix_log[k]) if (pix_log[k] !== pix_val(k)) e++;
        return e;
    endfunction

    function automatic int wr_seq_err();
        int e = 0;
        foreach (wr_addr_log[k]) begin
            if (wr_addr_log[k] !== ADDR_W'(k)) e++;
            if (wr_data_log[k] !== (pix_val(k) ^ 24'hFFFFFF)) e++;
        end
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     64'(o_busy),     64'd0);
        check({tag, "_done"},     64'(o_done),     64'd0);
        check({tag, "_rd_en"},    64'(o_rd_en),    64'd0);
        check({tag, "_pix_vld"},  64'(o_pix_vld),  64'd0);
        check({tag, "_wr_en"},    64'(o_wr_en),    64'd0);
        check({tag, "_res_busy"}, 64'(o_res_busy), 64'd1);
        check({tag, "_rd_addr"},  64'(o_rd_addr),  64'd0);
        check({tag, "_wr_addr"},  64'(o_wr_addr),  64'd0);
        check({tag, "_pix_data"}, 64'(o_pix_data), 64'd0);
        check({tag, "_wr_data"},  64'(o_wr_data),  64'd0);
    endtask

    initial begin
        int c;
        int wr_before;
        int rd_before;

        // Reset state
        repeat (3) step();
        check_reset_outputs("rst");
        i_rst = 1'b0;
        repeat (2) step();

        // 4x4 frame, no back-pressure, filter echoes after 3 cycles
        clear_logs();
        start_frame(4, 4, c);
        wait_done(200);
        check("t1_done_cnt",  64'(done_cnt),         64'd1);
        check("t1_rd_cnt",    64'(rd_log.size()),    64'd16);
        check("t1_rd_seq",    64'(rd_seq_err()),     64'd0);
        check("t1_pix_seq",   64'(pix_seq_err()),    64'd0);
        check("t1_wr_cnt",    64'(wr_addr_log.size()), 64'd16);
        check("t1_wr_seq",    64'(wr_seq_err()),     64'd0);
        check("t1_busy_gap",  64'(busy_gap),         64'd0);
        // Accepting edge ends cycle c; vld appears two edges later.
        check("t1_first_vld", 64'(first_vld_cyc - c), 64'd3);
        check("t1_rate",      64'(pix_cyc_last - pix_cyc_first), 64'd15);
        check("t1_done_at",   64'(done_cyc - wr_cyc_last), 64'd1);
        check("t1_max_out",   64'(max_out <= 2),     64'd1);
        check("t1_idle_busy", 64'(o_busy),           64'd0);

        // 4x2 frame, filter busy toggling every cycle
        clear_logs();
        busy_mode = 1;
        start_frame(4, 2, c);
        wait_done(300);
        busy_mode = 0;
        check("t2_done_cnt",  64'(done_cnt),         64'd1);
        check("t2_pix_cnt",   64'(pix_log.size()),   64'd8);
        check("t2_pix_seq",   64'(pix_seq_err()),    64'd0);
        check("t2_stable",    64'(stab_err),         64'd0);
        check("t2_max_out",   64'(max_out <= 2),     64'd1);
        check("t2_rd_cnt",    64'(rd_log.size()),    64'd8);
        check("t2_wr_cnt",    64'(wr_addr_log.size()), 64'd8);
        check("t2_wr_seq",    64'(wr_seq_err()),     64'd0);

        // Empty frame; start held into the DONE cycle must be ignored there
        clear_logs();
        step();
        i_width  = DIM_W'(0);
        i_height = DIM_W'(5);
        i_start  = 1'b1;
        in_frame = 1;
        c = cyc;
        step();
        step();
        i_start = 1'b0;
        repeat (4) step();
        check("t3_done_cnt",  64'(done_cnt),         64'd1);
        check("t3_done_at",   64'(done_cyc - c),     64'd1);
        check("t3_rd_cnt",    64'(rd_log.size()),    64'd0);
        check("t3_pix_cnt",   64'(pix_log.size()),   64'd0);
        check("t3_wr_cnt",    64'(wr_addr_log.size()), 64'd0);
        check("t3_idle_busy", 64'(o_busy),           64'd0);

        // 3x3 frame with an 8x8 start pulse mid-frame
        clear_logs();
        start_frame(3, 3, c);
        wait_pix(3, 50);
        i_width  = DIM_W'(8);
        i_height = DIM_W'(8);
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        wait_done(200);
        repeat (4) step();
        check("t4_done_cnt",  64'(done_cnt),         64'd1);
        check("t4_rd_cnt",    64'(rd_log.size()),    64'd9);
        check("t4_wr_cnt",    64'(wr_addr_log.size()), 64'd9);
        check("t4_wr_seq",    64'(wr_seq_err()),     64'd0);
        check("t4_idle_busy", 64'(o_busy),           64'd0);

        // 4x4 frame, all results held until after the last pixel, 10-cycle gaps
        clear_logs();
        gap_mode = 1;
        frame_n  = 16;
        start_frame(4, 4, c);
        wait_done(400);
        gap_mode = 0;
        check("t5_done_cnt",  64'(done_cnt),         64'd1);
        check("t5_wr_cnt",    64'(wr_addr_log.size()), 64'd16);
        check("t5_wr_seq",    64'(wr_seq_err()),     64'd0);
        check("t5_drain",     64'(drain_err),        64'd0);
        check("t5_first_wr",  64'(wr_cyc_first - pix_cyc_last), 64'd10);
        check("t5_done_at",   64'(done_cyc - wr_cyc_last), 64'd1);

        // Reset after 5 pixels of a 4x4 frame, then a fresh 2x2 frame
        clear_logs();
        start_frame(4, 4, c);
        wait_pix(5, 50);
        check("t6_reached_5", 64'(pix_log.size() >= 5), 64'd1);
        i_rst = 1'b1;
        in_frame = 0;
        #1;
        check_reset_outputs("t6_rst");
        wr_before = wr_addr_log.size();
        rd_before = rd_log.size();
        repeat (3) step();
        i_rst = 1'b0;
        repeat (6) step();
        check("t6_no_wr",     64'(wr_addr_log.size()), 64'(wr_before));
        check("t6_no_rd",     64'(rd_log.size()),    64'(rd_before));
        check("t6_idle_busy", 64'(o_busy),           64'd0);
        clear_logs();
        start_frame(2, 2, c);
        wait_done(100);
        check("t6_done_cnt",  64'(done_cnt),         64'd1);
        check("t6_rd_cnt",    64'(rd_log.size()),    64'd4);
        check("t6_wr_cnt",    64'(wr_addr_log.size()), 64'd4);
        check("t6_wr_seq",    64'(wr_seq_err()),     64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_sobel_frame_ctrl
